// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and elaboration-time helpers for the parallel radix-2 FFT.
//   cplx_t      : one complex sample in the default Q1.15 format, [0]=Re, [1]=Im
//   bitrev()    : index bit reversal used for the input permutation
//   tw_val()    : twiddle ROM entry (Re or Im of exp(-j*2*pi*m/span)),
//                 evaluated only at elaboration to form constants
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int DEF_POINT_FFT_POW2 = 4;
  localparam int DEF_FRAC_BITS      = 15;
  localparam real PI                = 3.14159265358979323846;

  typedef logic signed [1:0][DEF_FRAC_BITS:0] cplx_t;

  // Reverse the low 'bits' bits of idx.
  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r | (((idx >> b) & 1) << (bits - 1 - b));
    end
    return r;
  endfunction

  // Twiddle component in Q1.frac, rounded to nearest. +1.0 is not representable
  // so it saturates to 2**frac-1; -1.0 is exact.
  function automatic int tw_val(input int m, input int span, input int frac,
                                input bit is_im);
    real ang;
    real r;
    real scaled;
    int  v;
    int  lim;
    ang    = 2.0 * PI * real'(m) / real'(span);
    r      = is_im ? -$sin(ang) : $cos(ang);
    scaled = r * real'(1 << frac);
    v      = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    lim    = 1 << frac;
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
    return v;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// ---------------------------------------------------------------------------
// fft_butterfly
// Purely combinational scaled radix-2 DIT butterfly:
//   t  = W*b          (full-precision products, round half-up to Q1.FRAC_BITS)
//   A' = (a + t) / 2  (rounded: (sum+1)>>>1)
//   B' = (a - t) / 2
// Ports:
//   a_re_i/a_im_i  in   upper input of the pair
//   b_re_i/b_im_i  in   lower input of the pair
//   w_re_i/w_im_i  in   twiddle constant
//   ap_re_o/ap_im_o out A'
//   bp_re_o/bp_im_o out B'
// ---------------------------------------------------------------------------
module fft_butterfly #(
  parameter int FRAC_BITS = 15
) (
  input  logic signed [FRAC_BITS:0] a_re_i,
  input  logic signed [FRAC_BITS:0] a_im_i,
  input  logic signed [FRAC_BITS:0] b_re_i,
  input  logic signed [FRAC_BITS:0] b_im_i,
  input  logic signed [FRAC_BITS:0] w_re_i,
  input  logic signed [FRAC_BITS:0] w_im_i,
  output logic signed [FRAC_BITS:0] ap_re_o,
  output logic signed [FRAC_BITS:0] ap_im_o,
  output logic signed [FRAC_BITS:0] bp_re_o,
  output logic signed [FRAC_BITS:0] bp_im_o
);

  localparam int W  = FRAC_BITS + 1;
  localparam int PW = 2 * W + 1;
  // One guard bit beyond a+/-t: a W-rotated component can reach sqrt(2) in
  // magnitude, so the pre-halving sum may exceed +/-2 for corner inputs.
  localparam int SW = W + 3;

  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC_BITS - 1);

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0] t_re_full, t_im_full;
  logic signed [PW-1:0] t_re_rnd, t_im_rnd;
  logic signed [SW-1:0] t_re, t_im;
  logic signed [SW-1:0] s_ap_re, s_ap_im, s_bp_re, s_bp_im;
  logic signed [SW-1:0] h_ap_re, h_ap_im, h_bp_re, h_bp_im;

  assign p_rr = PW'(b_re_i) * PW'(w_re_i);
  assign p_ii = PW'(b_im_i) * PW'(w_im_i);
  assign p_ri = PW'(b_re_i) * PW'(w_im_i);
  assign p_ir = PW'(b_im_i) * PW'(w_re_i);

  assign t_re_full = p_rr - p_ii;
  assign t_im_full = p_ri + p_ir;

  // Round half-up back to Q1.FRAC_BITS.
  assign t_re_rnd = (t_re_full + RND) >>> FRAC_BITS;
  assign t_im_rnd = (t_im_full + RND) >>> FRAC_BITS;
  assign t_re     = SW'(t_re_rnd);
  assign t_im     = SW'(t_im_rnd);

  assign s_ap_re = SW'(a_re_i) + t_re;
  assign s_ap_im = SW'(a_im_i) + t_im;
  assign s_bp_re = SW'(a_re_i) - t_re;
  assign s_bp_im = SW'(a_im_i) - t_im;

  assign h_ap_re = (s_ap_re + SW'(1)) >>> 1;
  assign h_ap_im = (s_ap_im + SW'(1)) >>> 1;
  assign h_bp_re = (s_bp_re + SW'(1)) >>> 1;
  assign h_bp_im = (s_bp_im + SW'(1)) >>> 1;

  assign ap_re_o = W'(h_ap_re);
  assign ap_im_o = W'(h_ap_im);
  assign bp_re_o = W'(h_bp_re);
  assign bp_im_o = W'(h_bp_im);

endmodule

// File: rtl/top_fft.sv
// ---------------------------------------------------------------------------
// top_fft
// Fully pipelined, parallel-I/O radix-2 DIT FFT. One whole frame enters per
// clock; its spectrum X[k]/N leaves POINT_FFT_POW2 clocks later.
// Handshake: valid-only. valid_i marks data_i as a frame this cycle; valid_o
// marks data_o as a spectrum. There is no ready: the pipe never stalls, and
// data registers load every cycle regardless of valid.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (clears all stages and valids)
//   valid_i  in   frame present on data_i
//   data_i   in   x[n], natural order, [n][0]=Re, [n][1]=Im, Q1.FRAC_BITS
//   valid_o  out  spectrum present on data_o
//   data_o   out  X[k]/N, natural order, [k][0]=Re, [k][1]=Im
// ---------------------------------------------------------------------------
module top_fft
  import fft_pkg::*;
#(
  parameter int POINT_FFT_POW2 = 4,
  parameter int FRAC_BITS      = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic signed [1:0][FRAC_BITS:0] data_i [1 << POINT_FFT_POW2],
  output logic                          valid_o,
  output logic signed [1:0][FRAC_BITS:0] data_o [1 << POINT_FFT_POW2]
);

  localparam int N = 1 << POINT_FFT_POW2;
  localparam int P = POINT_FFT_POW2;

  typedef logic signed [1:0][FRAC_BITS:0] cplx_w_t;

  // stg[s] feeds stage s; bf[s] is the combinational result of stage s.
  cplx_w_t stg [P][N];
  cplx_w_t bf  [P][N];

  // Intermediate stage registers s0..s(P-2); the last stage lands in s3_out.
  cplx_w_t pipe_q [P-1][N];
  cplx_w_t s3_out [N];
  logic [P-1:0] vld_q;

  // Input permutation to bit-reversed order: wiring only.
  for (genvar n = 0; n < N; n++) begin : g_rev
    assign stg[0][n] = data_i[bitrev(n, P)];
  end

  for (genvar s = 1; s < P; s++) begin : g_link
    for (genvar n = 0; n < N; n++) begin : g_n
      assign stg[s][n] = pipe_q[s-1][n];
    end
  end

  for (genvar s = 0; s < P; s++) begin : g_stage
    localparam int H = 1 << s;
    for (genvar p = 0; p < N / 2; p++) begin : g_bf
      localparam int M  = p % H;
      localparam int I  = (p / H) * 2 * H + M;
      localparam int J  = I + H;
      localparam logic signed [FRAC_BITS:0] WR =
        (FRAC_BITS + 1)'(tw_val(M, 2 * H, FRAC_BITS, 1'b0));
      localparam logic signed [FRAC_BITS:0] WI =
        (FRAC_BITS + 1)'(tw_val(M, 2 * H, FRAC_BITS, 1'b1));

      fft_butterfly #(.FRAC_BITS(FRAC_BITS)) u_bf (
        .a_re_i  (stg[s][I][0]),
        .a_im_i  (stg[s][I][1]),
        .b_re_i  (stg[s][J][0]),
        .b_im_i  (stg[s][J][1]),
        .w_re_i  (WR),
        .w_im_i  (WI),
        .ap_re_o (bf[s][I][0]),
        .ap_im_o (bf[s][I][1]),
        .bp_re_o (bf[s][J][0]),
        .bp_im_o (bf[s][J][1])
      );
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < P - 1; s++) begin
        for (int n = 0; n < N; n++) begin
          pipe_q[s][n] <= '0;
        end
      end
      for (int n = 0; n < N; n++) begin
        s3_out[n] <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int s = 0; s < P - 1; s++) begin
        for (int n = 0; n < N; n++) begin
          pipe_q[s][n] <= bf[s][n];
        end
      end
      for (int n = 0; n < N; n++) begin
        s3_out[n] <= bf[P-1][n];
      end
      vld_q <= {vld_q[P-2:0], valid_i};
    end
  end

  assign valid_o = vld_q[P-1];
  assign data_o  = s3_out;

endmodule

// File: tb/tb_top_fft.sv
module tb_top_fft;

  localparam int P   = 4;
  localparam int N   = 16;
  localparam int FB  = 15;
  localparam int TOL = 4;
  localparam int NV  = 6;

  typedef struct {
    string name;
    int    in_re [N];
    int    in_im [N];
    int    ex_re [N];
    int    ex_im [N];
  } vec_t;

  logic clk;
  logic rst;
  logic valid_i;
  logic valid_o;
  logic signed [1:0][FB:0] data_i [N];
  logic signed [1:0][FB:0] data_o [N];

  int checks;
  int failures;
  vec_t vecs [NV];
  int c16 [N];

  top_fft #(.POINT_FFT_POW2(P), .FRAC_BITS(FB)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic check_spec(input int v);
    int got;
    for (int k = 0; k < N; k++) begin
      got = $signed(data_o[k][0]);
      check_val($sformatf("%s re[%0d]", vecs[v].name, k), got, vecs[v].ex_re[k], TOL);
      got = $signed(data_o[k][1]);
      check_val($sformatf("%s im[%0d]", vecs[v].name, k), got, vecs[v].ex_im[k], TOL);
    end
  endtask

  task automatic check_zero_out(input string tag);
    int nz;
    nz = 0;
    for (int k = 0; k < N; k++) begin
      if (data_o[k][0] != '0 || data_o[k][1] != '0) nz++;
    end
    check_val(tag, nz, 0, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_frame(input int v);
    for (int n = 0; n < N; n++) begin
      data_i[n][0] = (FB + 1)'(vecs[v].in_re[n]);
      data_i[n][1] = (FB + 1)'(vecs[v].in_im[n]);
    end
  endtask

  task automatic clear_frame();
    for (int n = 0; n < N; n++) begin
      data_i[n] = '0;
    end
  endtask

  // Present one frame for one cycle, wait for valid_o (bounded), check latency and spectrum.
  task automatic apply_vec(input int v);
    int lat;
    @(negedge clk);
    load_frame(v);
    valid_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        valid_i = 1'b0;
        clear_frame();
      end
    end while (!valid_o && lat < 10);
    check_val($sformatf("%s latency", vecs[v].name), lat, P, 0);
    if (valid_o) check_spec(v);
  endtask

  // ---------------- vector table ----------------
  task automatic build_table();
    // 16384*cos(2*pi*k/16); sin(k) = cos(k-4)
    c16 = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
            -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};
    for (int v = 0; v < NV; v++) begin
      for (int n = 0; n < N; n++) begin
        vecs[v].in_re[n] = 0; vecs[v].in_im[n] = 0;
        vecs[v].ex_re[n] = 0; vecs[v].ex_im[n] = 0;
      end
    end
    vecs[0].name = "dc";
    for (int n = 0; n < N; n++) vecs[0].in_re[n] = 16384;
    vecs[0].ex_re[0] = 16384;

    vecs[1].name = "tone3";
    for (int n = 0; n < N; n++) vecs[1].in_re[n] = c16[(3 * n) % N];
    vecs[1].ex_re[3]  = 8192;
    vecs[1].ex_re[13] = 8192;

    vecs[2].name = "impulse";
    vecs[2].in_re[0] = 16384;
    for (int k = 0; k < N; k++) vecs[2].ex_re[k] = 1024;

    vecs[3].name = "fullneg";
    for (int n = 0; n < N; n++) vecs[3].in_re[n] = -32768;
    vecs[3].ex_re[0] = -32768;

    vecs[4].name = "dc_imag";
    for (int n = 0; n < N; n++) vecs[4].in_im[n] = 16384;
    vecs[4].ex_im[0] = 16384;

    // Complex exponential at bin 5: 0.5*exp(+j*2*pi*5n/16) -> only X[5] = 0.5
    vecs[5].name = "cexp5";
    for (int n = 0; n < N; n++) begin
      vecs[5].in_re[n] = c16[(5 * n) % N];
      vecs[5].in_im[n] = c16[(5 * n + 12) % N];
    end
    vecs[5].ex_re[5] = 16384;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    build_table();
    valid_i = 1'b0;
    clear_frame();
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("reset valid_o", int'(valid_o), 0, 0);
    check_zero_out("reset data_o nonzero bins");
    rst = 1'b0;

    // Table-driven single frames
    for (int v = 0; v < NV; v++) begin
      apply_vec(v);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: dc, tone, impulse on consecutive cycles
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      load_frame(f);
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
    clear_frame();
    // Frame 0 was captured 3 negedges ago; outputs on steps 4,5,6 counting from its capture.
    for (int step = 3; step <= 9; step++) begin
      if (step >= 4 && step <= 6) begin
        check_val($sformatf("pipe valid_o step %0d", step), int'(valid_o), 1, 0);
        if (valid_o) check_spec(step - 4);
        if (step == 6) check_val("pipe s3_out[0].re", $signed(dut.s3_out[0][0]), 1024, TOL);
      end else begin
        check_val($sformatf("pipe valid_o step %0d", step), int'(valid_o), 0, 0);
      end
      @(negedge clk);
    end

    // Asynchronous reset with two frames in flight. Hold the DC frame on the
    // input so every stage register carries nonzero data.
    load_frame(0);
    repeat (5) @(negedge clk);
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    valid_i = 1'b0;
    // First frame was captured two edges back; two more edges put it on data_o.
    repeat (2) @(posedge clk);
    #1;
    check_val("pre-reset valid_o", int'(valid_o), 1, 0);
    check_val("pre-reset data_o[0].re", $signed(data_o[0][0]), 16384, TOL);
    #1;
    rst = 1'b1;
    #1;
    check_val("async reset valid_o", int'(valid_o), 0, 0);
    check_zero_out("async reset data_o nonzero bins");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_frame();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_val($sformatf("post-reset stale valid_o cyc %0d", c), int'(valid_o), 0, 0);
    end

    // Pipe still works after reset
    apply_vec(2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout guard
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
